esram_ahb_arbiter: RTL and testbench

- Single AHB-Lite master that shares the on-chip eSRAM between two requesters: the SDIO-side write path (FIFO fill) and the I2S-side read path (FIFO drain).
- After reset it issues a one-shot configuration write that disables the eSRAM controller pipeline, then serves requests one transfer at a time.
- Writes have priority. A streak limit guarantees reads are not starved.
- Sits between the FIFO pointer logic and the fabric AHB-Lite master port.

---
 rtl/esram_ahb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_esram_ahb_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esram_ahb_arbiter.sv
// Single AHB-Lite master sharing the eSRAM between the SDIO write path and the I2S read path.
// After reset it issues one pipeline-disable config write, then serves one transfer at a time.
module esram_ahb_arbiter #(
  parameter int unsigned ADDWID         = 14,
  parameter logic [31:0] ESRAM_BASE     = 32'h2000_0000,
  parameter logic [31:0] CFG_ADDR       = 32'h4003_8080,
  parameter logic [31:0] CFG_DATA       = 32'h0000_0000,
  parameter int unsigned STARTUP_CYCLES = 100,
  parameter int unsigned MAX_WR_STREAK  = 4
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDWID-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDWID-1:0] rd_addr,
  output logic              rd_ack,
  output logic [31:0]       rd_data,
  output logic              cfg_done,
  output logic              bus_err,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [31:0]       HRDATA,
  output logic [31:0]       HADDR,
  output logic [31:0]       HWDATA,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE
);

  localparam int unsigned     CNTW        = $clog2(STARTUP_CYCLES + 1);
  localparam int unsigned     STRW        = $clog2(MAX_WR_STREAK + 1);
  localparam logic [CNTW-1:0] CNT_LAST    = CNTW'(STARTUP_CYCLES - 1);
  localparam logic [STRW-1:0] STREAK_MAX  = STRW'(MAX_WR_STREAK);
  localparam logic [1:0]      HTRANS_IDLE = 2'b00;
  localparam logic [1:0]      HTRANS_NSEQ = 2'b10;

  typedef enum logic [2:0] {
    INIT,
    CFG_A,
    CFG_D,
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [STRW-1:0]   streak_q;
  logic [STRW-1:0]   streak_d;
  logic [31:0]       data_q;
  logic              err_q;
  logic              grant_wr;
  logic              grant_rd;
  logic [ADDWID-1:0] grant_addr;

  function automatic logic [31:0] esram_addr(input logic [ADDWID-1:0] a);
    return {ESRAM_BASE[31:ADDWID+2], a, 2'b00};
  endfunction

  assign HSIZE = 3'b010;

  // Writes win unless they have already taken MAX_WR_STREAK grants in a row over a waiting read.
  always_comb begin
    grant_wr   = wr_req && (!rd_req || (streak_q < STREAK_MAX));
    grant_rd   = rd_req && !grant_wr;
    grant_addr = grant_wr ? wr_addr : rd_addr;
    streak_d   = '0;
    if (grant_wr && rd_req) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STRW'(1);
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      streak_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      HTRANS   <= HTRANS_IDLE;
      HWRITE   <= 1'b0;
      HADDR    <= ESRAM_BASE;
      HWDATA   <= '0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_data  <= '0;
      cfg_done <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q < CNT_LAST) begin
            cnt_q <= cnt_q + CNTW'(1);
          end
          if ((cnt_q >= CNT_LAST) && HREADY) begin
            state_q <= CFG_A;
            HTRANS  <= HTRANS_NSEQ;
            HWRITE  <= 1'b1;
            HADDR   <= CFG_ADDR;
          end
        end
        CFG_A: begin
          if (HREADY) begin
            state_q <= CFG_D;
            HTRANS  <= HTRANS_IDLE;
            HWDATA  <= CFG_DATA;
          end
        end
        CFG_D: begin
          if (HRESP) begin
            bus_err <= 1'b1;
          end
          if (HREADY) begin
            state_q  <= IDLE;
            cfg_done <= 1'b1;
          end
        end
        IDLE: begin
          streak_q <= streak_d;
          if (grant_wr || grant_rd) begin
            state_q <= ADDR;
            data_q  <= wr_data;
            err_q   <= 1'b0;
            HTRANS  <= HTRANS_NSEQ;
            HWRITE  <= grant_wr;
            HADDR   <= esram_addr(grant_addr);
          end
        end
        ADDR: begin
          if (HREADY) begin
            state_q <= DATA;
            HTRANS  <= HTRANS_IDLE;
            if (HWRITE) begin
              HWDATA <= data_q;
            end
          end
        end
        DATA: begin
          if (HRESP) begin
            bus_err <= 1'b1;
            err_q   <= 1'b1;
          end
          if (HREADY) begin
            state_q <= DONE;
            if (HWRITE) begin
              wr_ack <= 1'b1;
            end else begin
              rd_ack  <= 1'b1;
              // An error response in any data-phase cycle poisons the returned word.
              rd_data <= (err_q || HRESP) ? '0 : HRDATA;
            end
          end
        end
        DONE: begin
          wr_ack  <= 1'b0;
          rd_ack  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_esram_ahb_arbiter.sv
// Bench for esram_ahb_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_esram_ahb_arbiter;

  localparam int          ADDWID     = 14;
  localparam logic [31:0] ESRAM_BASE = 32'h2000_0000;
  localparam logic [31:0] CFG_ADDR   = 32'h4003_8080;
  localparam logic [31:0] CFG_DATA   = 32'h0000_0000;
  localparam int          STARTUP    = 100;
  localparam int          MAXS       = 4;

  logic              mclk  = 1'b0;
  logic              reset = 1'b0;
  logic              wr_req, rd_req;
  logic [ADDWID-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data;
  logic              wr_ack, rd_ack, cfg_done, bus_err;
  logic [31:0]       rd_data;
  logic              HREADY, HRESP;
  logic [31:0]       HRDATA, HADDR, HWDATA;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc;
  bit          cmp_en  = 1'b0;

  // reference model state
  bit          m_cfg_started, m_active, m_is_cfg, m_err, m_gw, m_gr;
  int          m_step;
  int          m_init_cnt, m_streak;
  logic [31:0] m_wdata;
  logic [31:0] e_haddr, e_hwdata, e_rd_data;
  logic [1:0]  e_htrans;
  logic        e_hwrite, e_wr_ack, e_rd_ack, e_cfg_done, e_bus_err;

  // random-phase slave / requester bookkeeping
  bit          in_dp;
  logic [1:0]  prev_htrans;
  int unsigned n_wr_acks, n_rd_acks;

  esram_ahb_arbiter #(
    .ADDWID        (ADDWID),
    .ESRAM_BASE    (ESRAM_BASE),
    .CFG_ADDR      (CFG_ADDR),
    .CFG_DATA      (CFG_DATA),
    .STARTUP_CYCLES(STARTUP),
    .MAX_WR_STREAK (MAXS)
  ) dut (
    .mclk    (mclk),
    .reset   (reset),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .cfg_done(cfg_done),
    .bus_err (bus_err),
    .HREADY  (HREADY),
    .HRESP   (HRESP),
    .HRDATA  (HRDATA),
    .HADDR   (HADDR),
    .HWDATA  (HWDATA),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HSIZE   (HSIZE)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge mclk);
    #1;
  endtask

  // Transaction-level model: one transfer in flight, stepping address phase -> data phase -> turnaround.
  always @(posedge mclk or posedge reset) begin
    if (reset) begin
      m_cfg_started = 0; m_active = 0; m_is_cfg = 0; m_err = 0; m_step = 0;
      m_init_cnt = 0; m_streak = 0; m_wdata = '0;
      e_htrans = 2'b00; e_hwrite = 1'b0; e_haddr = ESRAM_BASE; e_hwdata = '0;
      e_wr_ack = 1'b0; e_rd_ack = 1'b0; e_rd_data = '0; e_cfg_done = 1'b0; e_bus_err = 1'b0;
    end else begin
      e_wr_ack = 1'b0;
      e_rd_ack = 1'b0;
      if (!m_active) begin
        if (!m_cfg_started) begin
          if (m_init_cnt >= STARTUP - 1 && HREADY) begin
            m_cfg_started = 1; m_active = 1; m_is_cfg = 1; m_step = 0; m_err = 0;
            e_hwrite = 1'b1; e_haddr = CFG_ADDR; m_wdata = CFG_DATA;
          end
          m_init_cnt++;
        end else begin
          m_gw = wr_req && (!rd_req || m_streak < MAXS);
          m_gr = rd_req && !m_gw;
          m_streak = (m_gw && rd_req) ? m_streak + 1 : 0;
          if (m_gw || m_gr) begin
            m_active = 1; m_is_cfg = 0; m_step = 0; m_err = 0;
            e_hwrite = m_gw;
            e_haddr  = ESRAM_BASE + 32'(m_gw ? wr_addr : rd_addr) * 32'd4;
            m_wdata  = wr_data;
          end
        end
      end else if (m_step == 0) begin
        if (HREADY) begin
          m_step = 1;
          if (e_hwrite) e_hwdata = m_wdata;
        end
      end else if (m_step == 1) begin
        if (HRESP) begin
          m_err = 1; e_bus_err = 1'b1;
        end
        if (HREADY) begin
          if (m_is_cfg) begin
            e_cfg_done = 1'b1; m_active = 0;
          end else begin
            m_step = 2;
            if (e_hwrite) e_wr_ack = 1'b1;
            else begin
              e_rd_ack  = 1'b1;
              e_rd_data = m_err ? 32'h0 : HRDATA;
            end
          end
        end
      end else begin
        m_active = 0;
      end
      e_htrans = (m_active && m_step == 0) ? 2'b10 : 2'b00;
    end
  end

  always @(negedge mclk) begin
    if (cmp_en && !reset) begin
      chk("HTRANS", 32'(HTRANS), 32'(e_htrans));
      chk("HWRITE", 32'(HWRITE), 32'(e_hwrite));
      chk("HADDR", HADDR, e_haddr);
      chk("HWDATA", HWDATA, e_hwdata);
      chk("HSIZE", 32'(HSIZE), 32'h2);
      chk("wr_ack", 32'(wr_ack), 32'(e_wr_ack));
      chk("rd_ack", 32'(rd_ack), 32'(e_rd_ack));
      chk("rd_data", rd_data, e_rd_data);
      chk("cfg_done", 32'(cfg_done), 32'(e_cfg_done));
      chk("bus_err", 32'(bus_err), 32'(e_bus_err));
    end
  end

  task automatic new_wr();
    wr_req  = 1'b1;
    wr_addr = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom);
    wr_data = $urandom;
  endtask

  task automatic new_rd();
    rd_req  = 1'b1;
    rd_addr = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom);
  endtask

  task automatic drive_random();
    if (in_dp && HREADY) in_dp = 1'b0;
    if (prev_htrans == 2'b10 && HREADY) in_dp = 1'b1;
    prev_htrans = HTRANS;
    if (in_dp) begin
      HREADY = ($urandom_range(0, 3) != 0);
      HRESP  = ($urandom_range(0, 15) == 0);
    end else begin
      HREADY = ($urandom_range(0, 7) != 0);
      HRESP  = 1'b0;
    end
    HRDATA = $urandom;
    if (wr_req) begin
      if (wr_ack) begin
        n_wr_acks++;
        if ($urandom_range(0, 1) == 1) new_wr(); else wr_req = 1'b0;
      end
    end else if ($urandom_range(0, 3) == 0) new_wr();
    if (rd_req) begin
      if (rd_ack) begin
        n_rd_acks++;
        if ($urandom_range(0, 1) == 1) new_rd(); else rd_req = 1'b0;
      end
    end else if ($urandom_range(0, 3) == 0) new_rd();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] order;
    int         ng, waited;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    n_wr_acks = 0; n_rd_acks = 0; in_dp = 1'b0; prev_htrans = 2'b00;
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    #2;
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h2000_0000);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_acks", 32'({wr_ack, rd_ack}), 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_flags", 32'({cfg_done, bus_err}), 32'h0);
    repeat (3) @(negedge mclk);
    #1 reset = 1'b0;

    // config write, no requests
    waited = 0;
    while (HTRANS !== 2'b10 && waited < 200) begin nxt(); waited++; end
    chk("cfg_addr_cycle", cyc, 100);
    chk("cfg_haddr", HADDR, 32'h4003_8080);
    chk("cfg_hwrite", 32'(HWRITE), 32'h1);
    nxt();
    chk("cfg_data_htrans", 32'(HTRANS), 32'h0);
    chk("cfg_hwdata", HWDATA, 32'h0);
    chk("cfg_done_early", 32'(cfg_done), 32'h0);
    nxt();
    chk("cfg_done_set", 32'(cfg_done), 32'h1);
    chk("cfg_done_cycle", cyc, 102);
    repeat (3) begin nxt(); chk("post_cfg_idle", 32'(HTRANS), 32'h0); end

    // single zero-wait write
    wr_addr = 14'h0005; wr_data = 32'hDEAD_BEEF; wr_req = 1'b1;
    nxt();
    chk("wr_htrans", 32'(HTRANS), 32'h2);
    chk("wr_haddr", HADDR, 32'h2000_0014);
    chk("wr_hwrite", 32'(HWRITE), 32'h1);
    chk("wr_ack_k", 32'(wr_ack), 32'h0);
    nxt();
    chk("wr_dphase_htrans", 32'(HTRANS), 32'h0);
    chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    chk("wr_ack_k1", 32'(wr_ack), 32'h0);
    nxt();
    chk("wr_ack_k2", 32'(wr_ack), 32'h1);
    wr_req = 1'b0;
    nxt();
    chk("wr_ack_k3", 32'(wr_ack), 32'h0);
    nxt();

    // read of the top word with three wait states
    rd_addr = 14'h3FFF; rd_req = 1'b1;
    nxt();
    chk("rd_htrans", 32'(HTRANS), 32'h2);
    chk("rd_haddr", HADDR, 32'h2000_FFFC);
    chk("rd_hwrite", 32'(HWRITE), 32'h0);
    nxt();
    HREADY = 1'b0;
    repeat (3) begin nxt(); chk("rd_ack_stalled", 32'(rd_ack), 32'h0); end
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    nxt();
    chk("rd_ack_late", 32'(rd_ack), 32'h1);
    chk("rd_data_val", rd_data, 32'h1234_5678);
    rd_req = 1'b0; HRDATA = 32'hFFFF_0000;
    nxt();
    chk("rd_ack_drop", 32'(rd_ack), 32'h0);
    nxt(); nxt();
    chk("rd_data_hold", rd_data, 32'h1234_5678);

    // both requests held: write streak then forced read
    wr_addr = 14'h0100; wr_data = 32'h5555_AAAA; rd_addr = 14'h0200;
    wr_req = 1'b1; rd_req = 1'b1;
    order = '0; ng = 0; waited = 0;
    while (ng < 10 && waited < 100) begin
      nxt(); waited++;
      if (HTRANS == 2'b10) begin order = {order[8:0], HWRITE}; ng++; end
    end
    chk("grant_order", 32'(order), 32'(10'b1111011110));
    nxt(); nxt();
    wr_req = 1'b0; rd_req = 1'b0;
    nxt(); nxt();

    // read with an error response over a stretched data phase
    rd_addr = 14'h0010; rd_req = 1'b1;
    nxt();
    chk("err_htrans", 32'(HTRANS), 32'h2);
    nxt();
    HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hAAAA_5555;
    nxt();
    chk("err_ack_wait", 32'(rd_ack), 32'h0);
    chk("err_bus_err", 32'(bus_err), 32'h1);
    HREADY = 1'b1;
    nxt();
    chk("err_rd_ack", 32'(rd_ack), 32'h1);
    chk("err_rd_data", rd_data, 32'h0);
    rd_req = 1'b0; HRESP = 1'b0;
    nxt();
    chk("err_ack_drop", 32'(rd_ack), 32'h0);
    chk("err_sticky", 32'(bus_err), 32'h1);
    nxt();

    // reset during the address phase
    wr_addr = 14'h0ABC; wr_data = 32'h0BAD_F00D; wr_req = 1'b1;
    nxt();
    chk("rst_mid_addr", 32'(HTRANS), 32'h2);
    reset = 1'b1;
    #1;
    chk("rst_mid_htrans", 32'(HTRANS), 32'h0);
    chk("rst_mid_haddr", HADDR, 32'h2000_0000);
    chk("rst_mid_flags", 32'({cfg_done, bus_err}), 32'h0);
    wr_req = 1'b0;
    repeat (3) begin nxt(); chk("rst_mid_no_ack", 32'({wr_ack, rd_ack}), 32'h0); end
    reset = 1'b0;

    // requests raised before the config write completes
    waited = 0;
    while (cyc < 10 && waited < 50) begin nxt(); waited++; end
    wr_addr = 14'h0123; wr_data = 32'hCAFE_F00D; rd_addr = 14'h0456;
    wr_req = 1'b1; rd_req = 1'b1;
    waited = 0;
    while (HTRANS !== 2'b10 && waited < 200) begin nxt(); waited++; end
    chk("early_cfg_cycle", cyc, 100);
    chk("early_cfg_haddr", HADDR, 32'h4003_8080);
    nxt(); nxt();
    chk("early_cfg_done", 32'(cfg_done), 32'h1);
    nxt();
    chk("early_grant_cycle", cyc, 103);
    chk("early_grant_htrans", 32'(HTRANS), 32'h2);
    chk("early_grant_write", 32'(HWRITE), 32'h1);
    chk("early_grant_haddr", HADDR, 32'h2000_048C);

    // randomized traffic with random wait states and error responses
    prev_htrans = 2'b00; in_dp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      nxt();
    end
    chk("random_wr_acks_seen", 32'(n_wr_acks >= 50), 32'h1);
    chk("random_rd_acks_seen", 32'(n_rd_acks >= 50), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
